// File: rtl/decode_stage_pipe.sv
// ============================================================================
// Module   : decode_stage_pipe
// Purpose  : MIPS-style ID stage: register file, immediate extension,
//            load-use hazard detection and a handshaked ID/EX register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module decode_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  output logic            id_ready,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [5:0]      ex_opcode,
  output logic [5:0]      ex_funct,
  output logic [4:0]      ex_rs,
  output logic [4:0]      ex_rt,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_rs_val,
  output logic [XLEN-1:0] ex_rt_val,
  output logic [XLEN-1:0] ex_imm,
  output logic            ex_mem_read
);

  localparam logic [5:0] c_NREGS   = 6'(NREGS);
  localparam logic [5:0] c_OP_LW   = 6'h23;
  localparam logic [5:0] c_OP_ANDI = 6'h0C;
  localparam logic [5:0] c_OP_ORI  = 6'h0D;
  localparam logic [5:0] c_OP_XORI = 6'h0E;

  // r0 has no storage; entries 1..NREGS-1 only
  logic [XLEN-1:0] r_regs [1:NREGS-1];

  logic            r_ex_valid;
  logic [5:0]      r_ex_opcode;
  logic [5:0]      r_ex_funct;
  logic [4:0]      r_ex_rs;
  logic [4:0]      r_ex_rt;
  logic [4:0]      r_ex_rd;
  logic [XLEN-1:0] r_ex_rs_val;
  logic [XLEN-1:0] r_ex_rt_val;
  logic [XLEN-1:0] r_ex_imm;
  logic            r_ex_mem_read;

  logic [5:0]      w_opcode;
  logic [5:0]      w_funct;
  logic [4:0]      w_rs;
  logic [4:0]      w_rt;
  logic [4:0]      w_rd;
  logic [15:0]     w_imm16;
  logic [XLEN-1:0] w_imm;
  logic            w_zext;
  logic            w_mem_read;
  logic            w_rs_ok;
  logic            w_rt_ok;
  logic [XLEN-1:0] w_rs_rf;
  logic [XLEN-1:0] w_rt_rf;
  logic [XLEN-1:0] w_rs_val;
  logic [XLEN-1:0] w_rt_val;
  logic            w_hazard;
  logic            w_stall;

  assign w_opcode   = if_instr[31:26];
  assign w_rs       = if_instr[25:21];
  assign w_rt       = if_instr[20:16];
  assign w_funct    = if_instr[5:0];
  assign w_imm16    = if_instr[15:0];
  assign w_rd       = (w_opcode == 6'd0) ? if_instr[15:11] : if_instr[20:16];
  assign w_mem_read = (w_opcode == c_OP_LW);
  assign w_zext     = (w_opcode == c_OP_ANDI) || (w_opcode == c_OP_ORI) ||
                      (w_opcode == c_OP_XORI);

  generate
    if (XLEN > 16) begin : g_imm_wide
      assign w_imm = w_zext ? {{(XLEN-16){1'b0}}, w_imm16}
                            : {{(XLEN-16){w_imm16[15]}}, w_imm16};
    end else begin : g_imm_narrow
      assign w_imm = w_imm16;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wb_we) begin
      for (int i = 1; i < NREGS; i++) begin
        if (wb_addr == 5'(i)) begin
          r_regs[i] <= wb_data;
        end
      end
    end
  end

  always_comb begin
    w_rs_rf = '0;
    w_rt_rf = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (w_rs == 5'(i)) begin
        w_rs_rf = r_regs[i];
      end
      if (w_rt == 5'(i)) begin
        w_rt_rf = r_regs[i];
      end
    end
  end

  // Out-of-range and r0 addresses never pick up a forwarded WB value
  assign w_rs_ok = ({1'b0, w_rs} < c_NREGS) && (w_rs != 5'd0);
  assign w_rt_ok = ({1'b0, w_rt} < c_NREGS) && (w_rt != 5'd0);

  generate
    if (BYPASS != 0) begin : g_bypass
      assign w_rs_val = (w_rs_ok && wb_we && (wb_addr == w_rs)) ? wb_data : w_rs_rf;
      assign w_rt_val = (w_rt_ok && wb_we && (wb_addr == w_rt)) ? wb_data : w_rt_rf;
    end else begin : g_no_bypass
      assign w_rs_val = w_rs_ok ? w_rs_rf : '0;
      assign w_rt_val = w_rt_ok ? w_rt_rf : '0;
    end
  endgenerate

  assign w_hazard = r_ex_valid && r_ex_mem_read && (r_ex_rt != 5'd0) &&
                    ((r_ex_rt == w_rs) || (r_ex_rt == w_rt));
  assign w_stall  = r_ex_valid && !ex_ready;
  assign id_ready = !w_hazard && !w_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_valid    <= 1'b0;
      r_ex_opcode   <= '0;
      r_ex_funct    <= '0;
      r_ex_rs       <= '0;
      r_ex_rt       <= '0;
      r_ex_rd       <= '0;
      r_ex_rs_val   <= '0;
      r_ex_rt_val   <= '0;
      r_ex_imm      <= '0;
      r_ex_mem_read <= 1'b0;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_stall) begin
      r_ex_valid <= r_ex_valid;
    end else if (w_hazard) begin
      r_ex_valid <= 1'b0;
    end else if (if_valid) begin
      r_ex_valid    <= 1'b1;
      r_ex_opcode   <= w_opcode;
      r_ex_funct    <= w_funct;
      r_ex_rs       <= w_rs;
      r_ex_rt       <= w_rt;
      r_ex_rd       <= w_rd;
      r_ex_rs_val   <= w_rs_val;
      r_ex_rt_val   <= w_rt_val;
      r_ex_imm      <= w_imm;
      r_ex_mem_read <= w_mem_read;
    end else begin
      r_ex_valid <= 1'b0;
    end
  end

  assign ex_valid    = r_ex_valid;
  assign ex_opcode   = r_ex_opcode;
  assign ex_funct    = r_ex_funct;
  assign ex_rs       = r_ex_rs;
  assign ex_rt       = r_ex_rt;
  assign ex_rd       = r_ex_rd;
  assign ex_rs_val   = r_ex_rs_val;
  assign ex_rt_val   = r_ex_rt_val;
  assign ex_imm      = r_ex_imm;
  assign ex_mem_read = r_ex_mem_read;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage_pipe.sv
// ============================================================================
// Module   : tb_decode_stage_pipe
// Purpose  : Self-checking bench for decode_stage_pipe (bypass and no-bypass).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_ready;

  logic [1:0]       a_rdy, a_valid, a_mr;
  logic [1:0][5:0]  a_op, a_fn;
  logic [1:0][4:0]  a_rs, a_rt, a_rd;
  logic [1:0][31:0] a_rsv, a_rtv, a_imm;

  always #5 clk = ~clk;

  decode_stage_pipe u_dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
    .id_ready(a_rdy[0]), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(a_valid[0]),
    .ex_opcode(a_op[0]), .ex_funct(a_fn[0]), .ex_rs(a_rs[0]), .ex_rt(a_rt[0]),
    .ex_rd(a_rd[0]), .ex_rs_val(a_rsv[0]), .ex_rt_val(a_rtv[0]),
    .ex_imm(a_imm[0]), .ex_mem_read(a_mr[0])
  );

  decode_stage_pipe #(.XLEN(32), .NREGS(16), .BYPASS(0)) u_dut_nb (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
    .id_ready(a_rdy[1]), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(a_valid[1]),
    .ex_opcode(a_op[1]), .ex_funct(a_fn[1]), .ex_rs(a_rs[1]), .ex_rt(a_rt[1]),
    .ex_rd(a_rd[1]), .ex_rs_val(a_rsv[1]), .ex_rt_val(a_rtv[1]),
    .ex_imm(a_imm[1]), .ex_mem_read(a_mr[1])
  );

  // Reference model: decoded instruction held in EX, one per DUT instance
  typedef struct {
    logic        valid;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rsv;
    logic [31:0] rtv;
    logic [31:0] imm;
    logic        mr;
  } ex_t;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] instr;
    logic [31:0] e_rsv;
    logic [31:0] e_rsv_nb;
    logic [31:0] e_imm;
    logic [4:0]  e_rd;
    logic        e_mr;
  } vec_t;

  ex_t         m_ex [2];
  logic [31:0] m_rf [2][32];
  vec_t        tbl  [6];
  int          n_pass   = 0;
  int          n_checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic int nregs_of(input int d);
    return (d == 0) ? 32 : 16;
  endfunction

  function automatic logic [31:0] m_read(input int d, input logic [4:0] a);
    if (a == 5'd0 || int'(a) >= nregs_of(d)) return 32'd0;
    if (d == 0 && wb_we && wb_addr == a) return wb_data;
    return m_rf[d][a];
  endfunction

  function automatic logic m_hazard(input int d);
    logic [4:0] rs;
    logic [4:0] rt;
    rs = if_instr[25:21];
    rt = if_instr[20:16];
    return m_ex[d].valid && m_ex[d].mr && (m_ex[d].rt != 5'd0) &&
           ((m_ex[d].rt == rs) || (m_ex[d].rt == rt));
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ex[d] = '{default: '0};
      for (int r = 0; r < 32; r++) m_rf[d][r] = 32'd0;
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      logic [5:0] op;
      op = if_instr[31:26];
      if (flush) m_ex[d].valid = 1'b0;
      else if (m_ex[d].valid && !ex_ready) m_ex[d].valid = 1'b1;
      else if (m_hazard(d)) m_ex[d].valid = 1'b0;
      else if (if_valid) begin
        m_ex[d].valid = 1'b1;
        m_ex[d].op    = op;
        m_ex[d].fn    = if_instr[5:0];
        m_ex[d].rs    = if_instr[25:21];
        m_ex[d].rt    = if_instr[20:16];
        m_ex[d].rd    = (op == 6'd0) ? if_instr[15:11] : if_instr[20:16];
        m_ex[d].rsv   = m_read(d, if_instr[25:21]);
        m_ex[d].rtv   = m_read(d, if_instr[20:16]);
        m_ex[d].imm   = (op inside {6'h0C, 6'h0D, 6'h0E}) ? {16'h0, if_instr[15:0]}
                                                          : {{16{if_instr[15]}}, if_instr[15:0]};
        m_ex[d].mr    = (op == 6'h23);
      end else m_ex[d].valid = 1'b0;
      if (wb_we && wb_addr != 5'd0 && int'(wb_addr) < nregs_of(d)) m_rf[d][wb_addr] = wb_data;
    end
  endtask

  task automatic check_outs();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_ex_valid", d), 32'(a_valid[d]), 32'(m_ex[d].valid));
      if (m_ex[d].valid) begin
        chk($sformatf("d%0d_opcode", d), 32'(a_op[d]), 32'(m_ex[d].op));
        chk($sformatf("d%0d_funct", d),  32'(a_fn[d]), 32'(m_ex[d].fn));
        chk($sformatf("d%0d_rs", d),     32'(a_rs[d]), 32'(m_ex[d].rs));
        chk($sformatf("d%0d_rt", d),     32'(a_rt[d]), 32'(m_ex[d].rt));
        chk($sformatf("d%0d_rd", d),     32'(a_rd[d]), 32'(m_ex[d].rd));
        chk($sformatf("d%0d_rs_val", d), a_rsv[d],     m_ex[d].rsv);
        chk($sformatf("d%0d_rt_val", d), a_rtv[d],     m_ex[d].rtv);
        chk($sformatf("d%0d_imm", d),    a_imm[d],     m_ex[d].imm);
        chk($sformatf("d%0d_mem_read", d), 32'(a_mr[d]), 32'(m_ex[d].mr));
      end
    end
  endtask

  // Inputs are set before the call; ready is checked mid-cycle, outputs 1 unit after the edge
  task automatic step();
    #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("d%0d_id_ready", d), 32'(a_rdy[d]),
          32'(!m_hazard(d) && (!m_ex[d].valid || ex_ready)));
    @(posedge clk);
    model_update();
    #1;
    check_outs();
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_d%0d_valid", tag, d),  32'(a_valid[d]), 32'd0);
      chk($sformatf("%s_d%0d_rs_val", tag, d), a_rsv[d], 32'd0);
      chk($sformatf("%s_d%0d_imm", tag, d),    a_imm[d], 32'd0);
      chk($sformatf("%s_d%0d_rd", tag, d),     32'(a_rd[d]), 32'd0);
      chk($sformatf("%s_d%0d_mem_read", tag, d), 32'(a_mr[d]), 32'd0);
    end
  endtask

  initial begin
    tbl[0] = '{5'd5,  32'h0000_1234, 32'h20A6FFFF, 32'h0000_1234, 32'h0000_1234, 32'hFFFF_FFFF, 5'd6, 1'b0};
    tbl[1] = '{5'd0,  32'h0000_0007, 32'h34018000, 32'h0,         32'h0,         32'h0000_8000, 5'd1, 1'b0};
    tbl[2] = '{5'd9,  32'hDEAD_BEEF, 32'h01202020, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_2020, 5'd4, 1'b0};
    tbl[3] = '{5'd1,  32'h0000_0100, 32'h8C220000, 32'h0000_0100, 32'h0000_0100, 32'h0,         5'd2, 1'b1};
    tbl[4] = '{5'd7,  32'h0000_0055, 32'h38A7F00F, 32'h0000_1234, 32'h0000_1234, 32'h0000_F00F, 5'd7, 1'b0};
    tbl[5] = '{5'd20, 32'h0000_0077, 32'h22830005, 32'h0000_0077, 32'h0,         32'h0000_0005, 5'd3, 1'b0};

    reset = 1'b1; if_valid = 1'b0; if_instr = 32'd0; wb_we = 1'b0; wb_addr = 5'd0;
    wb_data = 32'd0; flush = 1'b0; ex_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_zero("reset");
    chk("reset_id_ready", 32'(a_rdy[0]), 32'd1);

    // Directed decode vectors: write the source register, then decode
    for (int i = 0; i < 6; i++) begin
      wb_we = 1'b1; wb_addr = tbl[i].wa; wb_data = tbl[i].wd; if_valid = 1'b0; if_instr = 32'd0;
      step();
      wb_we = 1'b0; if_valid = 1'b1; if_instr = tbl[i].instr;
      step();
      chk($sformatf("vec%0d_valid", i),     32'(a_valid[0]), 32'd1);
      chk($sformatf("vec%0d_rs_val", i),    a_rsv[0], tbl[i].e_rsv);
      chk($sformatf("vec%0d_rs_val_nb", i), a_rsv[1], tbl[i].e_rsv_nb);
      chk($sformatf("vec%0d_imm", i),       a_imm[0], tbl[i].e_imm);
      chk($sformatf("vec%0d_rd", i),        32'(a_rd[0]), 32'(tbl[i].e_rd));
      chk($sformatf("vec%0d_mem_read", i),  32'(a_mr[0]), 32'(tbl[i].e_mr));
    end

    // Same-cycle WB write versus ID read
    if_valid = 1'b0; wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
    step();
    if_valid = 1'b1; if_instr = 32'h20640000; wb_data = 32'hAA;
    step();
    wb_we = 1'b0;
    chk("bypass_on_rs_val",  a_rsv[0], 32'hAA);
    chk("bypass_off_rs_val", a_rsv[1], 32'h11);

    // Load-use: exactly one bubble, then the dependent ADD issues
    if_instr = 32'h8C220000;
    step();
    chk("lu_load_valid", 32'(a_mr[0] & a_valid[0]), 32'd1);
    if_instr = 32'h00422020;
    #1 chk("lu_stall_ready", 32'(a_rdy[0]), 32'd0);
    step();
    chk("lu_bubble_valid", 32'(a_valid[0]), 32'd0);
    #1 chk("lu_resume_ready", 32'(a_rdy[0]), 32'd1);
    step();
    chk("lu_add_valid", 32'(a_valid[0]), 32'd1);
    chk("lu_add_rd",    32'(a_rd[0]), 32'd4);
    chk("lu_add_funct", 32'(a_fn[0]), 32'h20);

    // Backpressure for three cycles, then flush drops the offered instruction
    if_instr = 32'h34018000;
    step();
    ex_ready = 1'b0; if_instr = 32'h20A6FFFF;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("stall%0d_ready", c), 32'(a_rdy[0]), 32'd0);
      step();
      chk($sformatf("stall%0d_valid", c), 32'(a_valid[0]), 32'd1);
      chk($sformatf("stall%0d_imm", c),   a_imm[0], 32'h0000_8000);
      chk($sformatf("stall%0d_rd", c),    32'(a_rd[0]), 32'd1);
    end
    flush = 1'b1;
    step();
    chk("flush_valid", 32'(a_valid[0]), 32'd0);
    flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    step();
    chk("flush_dropped", 32'(a_valid[0]), 32'd0);

    // Asynchronous reset between edges
    if_valid = 1'b1; if_instr = 32'h20A6FFFF;
    step();
    chk("pre_reset_valid", 32'(a_valid[0]), 32'd1);
    if_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    model_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    if_valid = 1'b1; if_instr = 32'h20A6FFFF;
    step();
    chk("post_reset_r5",    a_rsv[0], 32'd0);
    chk("post_reset_r5_nb", a_rsv[1], 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [5:0] op;
      logic [4:0] rs;
      logic [4:0] rt;
      case ($urandom_range(0, 6))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h08;
        3: op = 6'h0C;
        4: op = 6'h0D;
        5: op = 6'h0E;
        default: op = 6'($urandom);
      endcase
      rs = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rt = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      if_instr = {op, rs, rt, 16'($urandom)};
      if_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      wb_we    = ($urandom_range(0, 1) == 1);
      wb_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
